// File: rtl/reg_serial_pkg.sv
// reg_serial_pkg: shared state encoding, default sizes and last-bit helper for reg_serial_tx
package reg_serial_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_e;
  localparam int DEF_WIDTH = 20;
  localparam int DEF_CNT_W = 5;
  function automatic int last_idx(input int width);
    return width - 1;
  endfunction
endpackage

// File: rtl/reg_serial_shreg.sv
// reg_serial_shreg: WIDTH-bit register with parallel load and zero-fill right shift, bit 0 out
module reg_serial_shreg import reg_serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             sh_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             bit0_o
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  always_comb shreg_d = ld_i ? d_i : sh_i ? {1'b0, shreg_q[WIDTH-1:1]} : shreg_q;
  always_ff @(posedge clk) shreg_q <= rst ? '0 : shreg_d;
  assign bit0_o = shreg_q[0];
endmodule

// File: rtl/reg_serial_tx.sv
// reg_serial_tx: LSB-first bit-serial reader of a parallel word with valid/ready handshake
// REG_SERIAL_TX_PARITY_EN adds an even-parity beat after the last data bit.
module reg_serial_tx import reg_serial_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] i,
  output logic             ready,
  output logic             busy,
  output logic             sdata,
  output logic             svalid,
  input  logic             sready,
  output logic             done
);
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam state_e AFTER_LAST = S_PARITY;
`else
  localparam state_e AFTER_LAST = S_DONE;
`endif
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ld, sh, last, bit0, par_bit;
  assign ld   = (state_q == S_IDLE) && load;
  assign sh   = (state_q == S_SHIFT) && sready;
  assign last = cnt_q == CNT_W'(last_idx(WIDTH));
  reg_serial_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk(clk), .rst(reset), .ld_i(ld), .sh_i(sh), .d_i(i), .bit0_o(bit0)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = load ? S_SHIFT : S_IDLE;
      S_SHIFT:  state_d = (sready && last) ? AFTER_LAST : S_SHIFT;
      S_PARITY: state_d = sready ? S_DONE : S_PARITY;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb cnt_d = ld ? '0 : sh ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef REG_SERIAL_TX_PARITY_EN
  logic par_q, par_d;
  always_comb par_d = ld ? 1'b0 : sh ? par_q ^ bit0 : par_q;
  always_ff @(posedge clk) par_q <= reset ? 1'b0 : par_d;
  assign par_bit = (state_q == S_PARITY) && par_q;
`else
  assign par_bit = 1'b0;
`endif
  assign ready  = state_q == S_IDLE;
  assign busy   = state_q != S_IDLE;
  assign svalid = (state_q == S_SHIFT) || (state_q == S_PARITY);
  assign done   = state_q == S_DONE;
  assign sdata  = ((state_q == S_SHIFT) && bit0) || par_bit;
endmodule

// File: tb/tb_reg_serial_tx.sv
// tb_reg_serial_tx: directed self-checking bench for reg_serial_tx (default and parity builds)
module tb_reg_serial_tx;
  localparam int W = 20;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  logic clk = 0, reset, load, sready, ready, busy, sdata, svalid, done;
  logic [W-1:0] i;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  reg_serial_tx #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .load(load), .i(i), .ready(ready), .busy(busy),
    .sdata(sdata), .svalid(svalid), .sready(sready), .done(done)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Loads w, collects the stream, stalls at beats 0 and 10, optionally pulses a load at beat busy_ld.
  task automatic xfer(input logic [W-1:0] w, input int st0, input int st10, input int busy_ld,
                      output logic [W:0] bits, output int nb, output int dc,
                      output bit hold_ok, output bit rdy_after);
    int s0, s10, cyc;
    bit seen, st, pulsed;
    s0 = 0; s10 = 0; seen = 0; pulsed = 0;
    bits = '0; nb = 0; dc = -1; hold_ok = 1; rdy_after = 0;
    for (int k = 0; k < 100 && !ready; k++) tick;
    load = 1; i = w; sready = 1;
    tick;
    load = 0; i = W'($urandom); cyc = 1;
    while (cyc < 200 && !seen) begin
      load = 0;
      if (done) begin
        dc = cyc;
        seen = 1;
      end else if (svalid) begin
        st = (nb == 0 && s0 < st0) || (nb == 10 && s10 < st10);
        if (st) begin
          if (nb == 0) s0++; else s10++;
          if (sdata !== w[nb]) hold_ok = 0;
        end else if (nb <= W) begin
          bits[nb] = sdata;
          nb++;
        end
        sready = !st;
        if (busy_ld >= 0 && nb == busy_ld && !pulsed) begin
          load = 1; i = '1; pulsed = 1;
        end
      end
      if (!seen) begin
        tick;
        cyc++;
      end
    end
    load = 0; sready = 1;
    if (seen) begin
      tick;
      rdy_after = ready;
    end
  endtask
  task automatic test_reset;
    reset = 1; load = 1; sready = 1; i = '1;
    tick; tick;
    load = 0;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL reset_ready got %b want 1", ready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (svalid !== 1'b0) begin nerr++; $display("FAIL reset_svalid got %b want 0", svalid); end
    nvec++; if (sdata !== 1'b0) begin nerr++; $display("FAIL reset_sdata got %b want 0", sdata); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    reset = 0;
    tick;
  endtask
  task automatic test_basic;
    logic [W:0] b; int nb, dc; bit h, r;
    xfer(20'hA5A5C, 0, 0, -1, b, nb, dc, h, r);
    nvec++; if (b !== {1'b0, 20'hA5A5C}) begin nerr++; $display("FAIL basic_bits got %h want %h", b, {1'b0, 20'hA5A5C}); end
    nvec++; if (nb !== W + P) begin nerr++; $display("FAIL basic_beats got %0d want %0d", nb, W + P); end
    nvec++; if (dc !== W + 1 + P) begin nerr++; $display("FAIL basic_done_cycle got %0d want %0d", dc, W + 1 + P); end
    nvec++; if (r !== 1'b1) begin nerr++; $display("FAIL basic_ready_after got %b want 1", r); end
  endtask
  task automatic test_backpressure;
    logic [W:0] b; int nb, dc; bit h, r;
    xfer(20'h00001, 3, 2, -1, b, nb, dc, h, r);
    nvec++; if (b !== {1'(P), 20'h00001}) begin nerr++; $display("FAIL bp_bits got %h want %h", b, {1'(P), 20'h00001}); end
    nvec++; if (dc !== W + 6 + P) begin nerr++; $display("FAIL bp_done_cycle got %0d want %0d", dc, W + 6 + P); end
    nvec++; if (h !== 1'b1) begin nerr++; $display("FAIL bp_hold got %b want 1", h); end
  endtask
  task automatic test_load_busy;
    logic [W:0] b; int nb, dc; bit h, r, quiet;
    xfer(20'h3C0F1, 0, 0, 5, b, nb, dc, h, r);
    nvec++; if (b[W-1:0] !== 20'h3C0F1) begin nerr++; $display("FAIL lb_bits got %h want 3c0f1", b[W-1:0]); end
    nvec++; if (dc !== W + 1 + P) begin nerr++; $display("FAIL lb_done_cycle got %0d want %0d", dc, W + 1 + P); end
    quiet = r;
    for (int k = 0; k < 3; k++) begin
      if (svalid !== 1'b0 || ready !== 1'b1) quiet = 0;
      tick;
    end
    nvec++; if (quiet !== 1'b1) begin nerr++; $display("FAIL lb_no_second got %b want 1", quiet); end
  endtask
  task automatic test_reset_mid;
    logic [W:0] b; int nb, dc; bit h, r, nodone;
    for (int k = 0; k < 100 && !ready; k++) tick;
    load = 1; i = 20'h12345; sready = 1;
    tick;
    load = 0;
    for (int k = 0; k < 8; k++) tick;
    nvec++; if (sdata !== 1'b1) begin nerr++; $display("FAIL rm_bit8 got %b want 1", sdata); end
    reset = 1;
    tick;
    reset = 0;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL rm_ready got %b want 1", ready); end
    nvec++; if (svalid !== 1'b0) begin nerr++; $display("FAIL rm_svalid got %b want 0", svalid); end
    nvec++; if (sdata !== 1'b0) begin nerr++; $display("FAIL rm_sdata got %b want 0", sdata); end
    nodone = 1;
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0) nodone = 0;
      tick;
    end
    nvec++; if (nodone !== 1'b1) begin nerr++; $display("FAIL rm_no_done got %b want 1", nodone); end
    xfer(20'h00003, 0, 0, -1, b, nb, dc, h, r);
    nvec++; if (b !== {1'b0, 20'h00003}) begin nerr++; $display("FAIL rm_fresh_bits got %h want %h", b, {1'b0, 20'h00003}); end
  endtask
  task automatic test_parity;
    logic [W:0] b; int nb, dc; bit h, r;
    xfer(20'h00007, 0, 0, -1, b, nb, dc, h, r);
    nvec++; if (b !== {1'(P), 20'h00007}) begin nerr++; $display("FAIL par7_bits got %h want %h", b, {1'(P), 20'h00007}); end
    nvec++; if (dc !== W + 1 + P) begin nerr++; $display("FAIL par7_done_cycle got %0d want %0d", dc, W + 1 + P); end
    xfer(20'h00003, 0, 0, -1, b, nb, dc, h, r);
    nvec++; if (b !== {1'b0, 20'h00003}) begin nerr++; $display("FAIL par3_bits got %h want %h", b, {1'b0, 20'h00003}); end
    nvec++; if (nb !== W + P) begin nerr++; $display("FAIL par3_beats got %0d want %0d", nb, W + P); end
  endtask
  task automatic test_back_to_back;
    int last, nacc, gap_bad, overlap;
    last = -1; nacc = 0; gap_bad = 0; overlap = 0;
    for (int k = 0; k < 100 && !ready; k++) tick;
    load = 1; i = 20'h5A5A5; sready = 1;
    for (int c = 0; c < 3 * (W + 2 + P) + 3; c++) begin
      if (ready && done) overlap++;
      if (ready) begin
        if (last >= 0 && c - last != W + 2 + P) gap_bad++;
        last = c;
        nacc++;
      end
      tick;
    end
    load = 0;
    nvec++; if (nacc !== 4) begin nerr++; $display("FAIL b2b_accepts got %0d want 4", nacc); end
    nvec++; if (gap_bad !== 0) begin nerr++; $display("FAIL b2b_gap got %0d bad want 0", gap_bad); end
    nvec++; if (overlap !== 0) begin nerr++; $display("FAIL b2b_overlap got %0d want 0", overlap); end
    for (int k = 0; k < W + 5; k++) tick;
    nvec++; if (ready !== 1'b1) begin nerr++; $display("FAIL b2b_drain_ready got %b want 1", ready); end
  endtask
  initial begin
    reset = 1; load = 0; sready = 0; i = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_load_busy;
    test_reset_mid;
    test_parity;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
